// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use and multi-cycle-unit
// interlocks, branch flushes, and a saturating count of decode stalls.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1D,
  input  logic [AW-1:0]    rs2D,
  input  logic             MulD,
  input  logic [AW-1:0]    rs1E,
  input  logic [AW-1:0]    rs2E,
  input  logic [AW-1:0]    rdE,
  input  logic [1:0]       DdataSelE,
  input  logic             MulStartE,
  input  logic             PCSrcE,
  input  logic [AW-1:0]    rdM,
  input  logic [AW-1:0]    rdWB,
  input  logic             RegWEnM,
  input  logic             RegWEnWB,
  output logic [1:0]       Fwd1,
  output logic [1:0]       Fwd2,
  output logic             FlushE,
  output logic             FlushD,
  output logic             StallD,
  output logic             StallF,
  output logic             MulBusy,
  output logic             MulDone,
  output logic [AW-1:0]    rdMul,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int LW = 4;

  logic             mul_busy_q, mul_busy_d;
  logic [LW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [AW-1:0]    rd_mul_q, rd_mul_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic match_rde, match_rdmul, load_use, mul_haz;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs, input logic [AW-1:0] rd_m,
                                         input logic wen_m, input logic [AW-1:0] rd_wb,
                                         input logic wen_wb);
    if (rs != '0 && rs == rd_m && wen_m)        return 2'b01;
    else if (rs != '0 && rs == rd_wb && wen_wb) return 2'b10;
    else                                        return 2'b00;
  endfunction

  always_comb begin
    Fwd1 = fwd_sel(rs1E, rdM, RegWEnM, rdWB, RegWEnWB);
    Fwd2 = fwd_sel(rs2E, rdM, RegWEnM, rdWB, RegWEnWB);
  end

  // Each decode operand matches on its own; register 0 never creates a dependency.
  always_comb begin
    match_rde   = (rs1D == rdE && rs1D != '0) || (rs2D == rdE && rs2D != '0);
    match_rdmul = (rs1D == rd_mul_q && rs1D != '0) || (rs2D == rd_mul_q && rs2D != '0);
    load_use    = (DdataSelE == 2'b00) && (rdE != '0) && match_rde;
    mul_haz     = mul_busy_q && ((match_rdmul && rd_mul_q != '0) || MulD);
  end

  always_comb begin
    FlushD = 1'b0;
    FlushE = 1'b0;
    StallD = 1'b0;
    StallF = 1'b0;
    if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use || mul_haz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // A branch in E never cancels the multi-cycle op: that op is older.
  always_comb begin
    mul_busy_d  = mul_busy_q;
    mul_cnt_d   = mul_cnt_q;
    rd_mul_d    = rd_mul_q;
    stall_cnt_d = stall_cnt_q;
    if (mul_busy_q) begin
      if (mul_cnt_q == '0) mul_busy_d = 1'b0;
      else                 mul_cnt_d  = mul_cnt_q - 1'b1;
    end else if (MulStartE) begin
      mul_busy_d = 1'b1;
      mul_cnt_d  = LW'(MUL_LAT - 1);
      rd_mul_d   = rdE;
    end
    if (StallD && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_busy_q  <= 1'b0;
      mul_cnt_q   <= '0;
      rd_mul_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      mul_busy_q  <= mul_busy_d;
      mul_cnt_q   <= mul_cnt_d;
      rd_mul_q    <= rd_mul_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MulBusy  = mul_busy_q;
  assign MulDone  = mul_busy_q && (mul_cnt_q == '0);
  assign rdMul    = rd_mul_q;
  assign StallCnt = stall_cnt_q;

endmodule
